// File: rtl/ps2_key_decoder_if.sv
// Key-event handshake between the PS/2 decoder and its consumer.
// The FIFO head is valid while key_valid is high; key_ready pops it.
interface ps2_key_decoder_if;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_brk;
    logic       key_valid;
    logic       key_ready;

    modport master (
        output key_code,
        output key_ext,
        output key_brk,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_ext,
        input  key_brk,
        input  key_valid,
        output key_ready
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames scan codes, folds E0/F0 prefixes into flags,
// and queues key events in a first-word-fall-through FIFO with sticky errors.
module ps2_key_decoder #(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    ps2_key_decoder_if.master    key,
    output logic [FIFO_AW:0]     fifo_count,
    output logic                 overflow,
    output logic                 parity_err,
    output logic                 timeout_err,
    input  logic                 clr_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    logic [2:0]       clk_sync;
    logic [2:0]       data_sync;
    logic [9:0]       shift;
    logic [3:0]       bit_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             byte_valid;
    logic [7:0]       byte_q;
    logic             ext_pend;
    logic             brk_pend;

    key_event_t       mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    key_event_t       head;

    logic strobe;
    logic frame_end;
    logic frame_ok;
    logic wd_fire;
    logic is_prefix;
    logic push_req;
    logic full;
    logic pop;
    logic do_push;
    logic ovf_set;
    logic perr_set;

    // Falling edge of the synchronised PS/2 clock marks a valid data bit.
    assign strobe    = clk_sync[2] & ~clk_sync[1];
    assign frame_end = strobe && (bit_cnt == 4'd10);

    // shift[0] = start, shift[8:1] = D0..D7, shift[9] = parity; stop arrives live.
    assign frame_ok  = ~shift[0] & data_sync[2] & (^shift[9:1]);

    assign wd_fire   = (bit_cnt != 4'd0) && !strobe && (wd_cnt == WD_LAST);

    assign is_prefix = (byte_q == PREFIX_EXT) || (byte_q == PREFIX_BRK);
    assign push_req  = byte_valid && !is_prefix;
    assign full      = (fifo_count == FULL_CNT);
    assign pop       = key.key_valid && key.key_ready;
    assign do_push   = push_req && (!full || pop);
    assign ovf_set   = push_req && full && !pop;
    assign perr_set  = frame_end && !frame_ok;

    // Receiver: synchronisers, bit framing and the partial-frame watchdog.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            clk_sync   <= 3'b111;
            data_sync  <= 3'b111;
            shift      <= '0;
            bit_cnt    <= '0;
            wd_cnt     <= '0;
            byte_valid <= 1'b0;
            byte_q     <= '0;
        end else begin
            clk_sync   <= {clk_sync[1:0], ps2_clk};
            data_sync  <= {data_sync[1:0], ps2_data};
            byte_valid <= 1'b0;
            if (strobe) begin
                shift  <= {data_sync[2], shift[9:1]};
                wd_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt    <= '0;
                    byte_valid <= frame_ok;
                    byte_q     <= shift[8:1];
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (wd_fire) begin
                    bit_cnt <= '0;
                    wd_cnt  <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    // Prefix tracking: a bad frame or a timeout forgets any half-seen sequence.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (perr_set || wd_fire) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (byte_valid) begin
            if (byte_q == PREFIX_EXT) begin
                ext_pend <= 1'b1;
            end else if (byte_q == PREFIX_BRK) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    // NOTE: event storage has no reset; empty-state outputs are masked by key_valid instead.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= '{ext: ext_pend, brk: brk_pend, code: byte_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky flags: a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            overflow    <= 1'b0;
            parity_err  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overflow    <= (overflow    & ~clr_err) | ovf_set;
            parity_err  <= (parity_err  & ~clr_err) | perr_set;
            timeout_err <= (timeout_err & ~clr_err) | wd_fire;
        end
    end

    assign head          = mem[rd_ptr];
    assign key.key_valid = (fifo_count != '0);
    assign key.key_code  = key.key_valid ? head.code : 8'h00;
    assign key.key_ext   = key.key_valid & head.ext;
    assign key.key_brk   = key.key_valid & head.brk;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: vector table, directed corner cases,
// and randomized frames checked against a byte-level event model.
module tb_ps2_key_decoder;

    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int TMO     = 300;
    localparam int H       = 4;

    logic clk      = 1'b0;
    logic clrn     = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    logic clr_err  = 1'b0;
    logic [FIFO_AW:0] fifo_count;
    logic overflow;
    logic parity_err;
    logic timeout_err;

    ps2_key_decoder_if kif();

    ps2_key_decoder #(.FIFO_AW(FIFO_AW), .TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key        (kif),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .parity_err (parity_err),
        .timeout_err(timeout_err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pops     = 0;
    bit rand_en  = 1'b0;

    // Reference model: byte-level prefix folding and an event queue.
    logic [9:0] exp_q [$];
    bit m_ext = 1'b0;
    bit m_brk = 1'b0;
    bit m_perr = 1'b0;
    bit m_ovf = 1'b0;

    typedef struct {
        logic [7:0] b;
        bit         flip;
        bit         ev;
        logic [7:0] code;
        bit         ext;
        bit         brk;
        bit         perr;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            m_ext  = 1'b0;
            m_brk  = 1'b0;
            m_perr = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
            else exp_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic logic [10:0] frame_of(input logic [7:0] b, input bit flip);
        logic par;
        par = ~(^b) ^ flip;
        return {1'b1, par, b, 1'b0};
    endfunction

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_en) kif.key_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            tick(H);
            ps2_clk = 1'b0;
            tick(H);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit flip);
        logic [10:0] f;
        f = frame_of(b, flip);
        send_bits(f, 10);
        ps2_data = f[10];
        tick(H);
        ps2_clk = 1'b0;
        model_frame(b, !flip);
        tick(H);
        ps2_clk = 1'b1;
        tick(2);
    endtask

    task automatic pop_one();
        kif.key_ready = 1'b1;
        tick(1);
        kif.key_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        m_perr  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic drain(input string name, input int expect_n);
        int p0;
        p0 = pops;
        kif.key_ready = 1'b1;
        tick(DEPTH + 4);
        kif.key_ready = 1'b0;
        check({name, "_popped"}, pops - p0, expect_n);
        check({name, "_count"}, fifo_count, 0);
    endtask

    // Every consumed event must be the next one the model predicts.
    always @(negedge clk) begin
        if (clrn && kif.key_valid && kif.key_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_unexpected: got %0h expected no event",
                         {kif.key_ext, kif.key_brk, kif.key_code});
            end else begin
                check("pop_event", {kif.key_ext, kif.key_brk, kif.key_code}, exp_q.pop_front());
                pops++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "time limit");
    end

    initial begin
        logic [10:0] f;
        logic [7:0]  b;
        int          r;

        tbl[0]  = '{8'h1C, 0, 1, 8'h1C, 0, 0, 0};
        tbl[1]  = '{8'hE0, 0, 0, 8'h00, 0, 0, 0};
        tbl[2]  = '{8'hF0, 0, 0, 8'h00, 0, 0, 0};
        tbl[3]  = '{8'h75, 0, 1, 8'h75, 1, 1, 0};
        tbl[4]  = '{8'h1C, 1, 0, 8'h00, 0, 0, 1};
        tbl[5]  = '{8'hF0, 0, 0, 8'h00, 0, 0, 0};
        tbl[6]  = '{8'h33, 1, 0, 8'h00, 0, 0, 1};
        tbl[7]  = '{8'h1C, 0, 1, 8'h1C, 0, 0, 0};
        tbl[8]  = '{8'hF0, 0, 0, 8'h00, 0, 0, 0};
        tbl[9]  = '{8'hF0, 0, 0, 8'h00, 0, 0, 0};
        tbl[10] = '{8'h5A, 0, 1, 8'h5A, 0, 1, 0};
        tbl[11] = '{8'hE0, 0, 0, 8'h00, 0, 0, 0};
        tbl[12] = '{8'h6B, 0, 1, 8'h6B, 1, 0, 0};

        kif.key_ready = 1'b0;

        // Reset state.
        clrn = 1'b0;
        tick(3);
        check("rst_valid", kif.key_valid, 0);
        check("rst_code", kif.key_code, 0);
        check("rst_ext_brk", {kif.key_ext, kif.key_brk}, 0);
        check("rst_count", fifo_count, 0);
        check("rst_flags", {overflow, parity_err, timeout_err}, 0);
        clrn = 1'b1;
        tick(2);

        // Vector table: one frame per row, head inspected then popped.
        for (int i = 0; i < 13; i++) begin
            send_byte(tbl[i].b, tbl[i].flip);
            check($sformatf("tbl%0d_valid", i), kif.key_valid, tbl[i].ev);
            check($sformatf("tbl%0d_count", i), fifo_count, tbl[i].ev);
            check($sformatf("tbl%0d_perr", i), parity_err, tbl[i].perr);
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_head", i), {kif.key_ext, kif.key_brk, kif.key_code},
                      {tbl[i].ext, tbl[i].brk, tbl[i].code});
                pop_one();
                check($sformatf("tbl%0d_popped", i), fifo_count, 0);
            end
            if (tbl[i].perr) begin
                pulse_clr();
                check($sformatf("tbl%0d_perr_clr", i), parity_err, 0);
            end
        end

        // key_valid rises exactly 2 cycles after the stop-bit strobe.
        f = frame_of(8'h1C, 1'b0);
        send_bits(f, 10);
        ps2_data = 1'b1;
        tick(H);
        ps2_clk = 1'b0;
        model_frame(8'h1C, 1'b1);
        tick(3);
        check("lat_not_yet", kif.key_valid, 0);
        tick(1);
        check("lat_valid", kif.key_valid, 1);
        check("lat_code", kif.key_code, 8'h1C);
        ps2_clk = 1'b1;
        tick(2);
        pop_one();

        // Overflow: 9 codes into an 8-deep FIFO with no consumer.
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 1'b0);
        check("ovf_count", fifo_count, DEPTH);
        check("ovf_flag", overflow, 1);
        check("ovf_model", overflow, m_ovf);
        check("ovf_head", kif.key_code, 8'h10);
        drain("ovf_drain", 8);
        pulse_clr();
        check("ovf_clr", overflow, 0);

        // Push and pop in the same cycle while full.
        for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i), 1'b0);
        f = frame_of(8'h2F, 1'b0);
        send_bits(f, 10);
        ps2_data = 1'b1;
        tick(H);
        ps2_clk = 1'b0;
        tick(3);
        kif.key_ready = 1'b1;
        tick(1);
        kif.key_ready = 1'b0;
        model_frame(8'h2F, 1'b1);
        check("fullpp_count", fifo_count, DEPTH);
        check("fullpp_ovf", overflow, 0);
        check("fullpp_head", kif.key_code, 8'h21);
        ps2_clk = 1'b1;
        tick(2);
        drain("fullpp_drain", 8);

        // clr_err coinciding with a new parity error leaves the flag set.
        f = frame_of(8'h44, 1'b1);
        send_bits(f, 10);
        ps2_data = 1'b1;
        tick(H);
        ps2_clk = 1'b0;
        model_frame(8'h44, 1'b0);
        tick(2);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("perr_set_wins", parity_err, 1);
        tick(1);
        ps2_clk = 1'b1;
        tick(2);
        pulse_clr();
        check("perr_clr", parity_err, 0);

        // Watchdog: abandoned partial frame, pending F0 forgotten.
        send_byte(8'hF0, 1'b0);
        send_bits(frame_of(8'h55, 1'b0), 4);
        tick(TMO - 20);
        check("tmo_not_early", timeout_err, 0);
        tick(40);
        m_ext = 1'b0;
        m_brk = 1'b0;
        check("tmo_flag", timeout_err, 1);
        send_byte(8'h69, 1'b0);
        check("tmo_next_head", {kif.key_valid, kif.key_ext, kif.key_brk, kif.key_code}, {3'b100, 8'h69});
        check("tmo_no_perr", parity_err, 0);
        pop_one();
        pulse_clr();
        check("tmo_clr", timeout_err, 0);

        // Reset mid-frame with events queued and flags set.
        send_byte(8'h66, 1'b1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'hF0, 1'b0);
        check("prerst_count", fifo_count, 3);
        send_bits(frame_of(8'h12, 1'b0), 5);
        clrn = 1'b0;
        tick(1);
        clrn = 1'b1;
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_perr = 1'b0;
        m_ovf = 1'b0;
        check("midrst_valid", kif.key_valid, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_outs", {kif.key_ext, kif.key_brk, kif.key_code}, 0);
        check("midrst_flags", {overflow, parity_err, timeout_err}, 0);
        ps2_data = 1'b1;
        tick(2);
        send_byte(8'h70, 1'b0);
        check("postrst_head", {kif.key_valid, kif.key_ext, kif.key_brk, kif.key_code}, {3'b100, 8'h70});
        check("postrst_perr", parity_err, 0);
        pop_one();

        // Randomized frames with a randomly stalling consumer.
        rand_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else b = 8'($urandom_range(0, 255));
            send_byte(b, $urandom_range(0, 9) == 0);
        end
        rand_en = 1'b0;
        kif.key_ready = 1'b1;
        tick(DEPTH + 4);
        kif.key_ready = 1'b0;
        check("rand_all_seen", exp_q.size(), 0);
        check("rand_count", fifo_count, 0);
        check("rand_perr", parity_err, m_perr);
        check("rand_ovf", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL provide parameter FIFO_AW, default 3, meaning log2 of event FIFO depth; depth = 2**FIFO_AW.
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 100000, meaning clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 clrn  in  1  reset, synchronous, active-low.
REQ-005 ps2_clk  in  1  asynchronous PS/2 clock from the device.
REQ-006 ps2_data  in  1  asynchronous PS/2 data from the device.
REQ-007 key_code  out  8  scan code of the head event.
REQ-008 key_ext  out  1  head event was preceded by an E0 prefix.
REQ-009 key_brk  out  1  head event was preceded by an F0 prefix (key release).
REQ-010 key_valid  out  1  FIFO non-empty; key_code/key_ext/key_brk are valid.
REQ-011 key_ready  in  1  consumer accepts the head event.
REQ-012 fifo_count  out  FIFO_AW+1  number of stored events.
REQ-013 overflow  out  1  sticky; an event was dropped because the FIFO was full.
REQ-014 parity_err  out  1  sticky; a frame failed the parity, start or stop check.
REQ-015 timeout_err  out  1  sticky; a partial frame was abandoned.
REQ-016 clr_err  in  1  a one-cycle pulse clears all three sticky flags.

Function
REQ-017 SHALL pass ps2_clk and ps2_data each through a 3-flop synchroniser; the sample strobe is sync[2] & ~sync[1], i.e. a falling edge.
REQ-018 SHALL capture the synchronised ps2_data on each strobe into an 11-bit shift register; bit counter 0..10; frame order start, D0..D7 LSB first, parity, stop.
REQ-019 On the 11th strobe, SHALL accept the frame only if start==0, stop==1 and XOR of D0..D7 and the parity bit == 1 (odd parity); the counter returns to 0 either way.
REQ-020 A rejected frame SHALL set parity_err, SHALL be discarded, and SHALL clear any pending E0/F0 prefix state.
REQ-021 Prefix decoder: accepted byte E0 sets ext_pend; F0 sets brk_pend; neither byte is pushed to the FIFO.
REQ-022 Any other accepted byte SHALL push {ext_pend, brk_pend, byte} into the FIFO and clear both pend flags in the same cycle.
REQ-023 Sequence E0,F0,xx SHALL yield ext=1, brk=1; a repeated prefix is idempotent.
REQ-024 Push occurs on the clk cycle after the stop-bit strobe; key_valid rises on the following cycle (2 cycles after the strobe, FIFO initially empty).
REQ-025 The FIFO SHALL be first-word-fall-through; the head is presented while key_valid=1, and a pop occurs when key_valid & key_ready.
REQ-026 Push with the FIFO full and no pop in the same cycle: the event is dropped, overflow is set, and FIFO contents are unchanged.
REQ-027 Push and pop in the same cycle when full SHALL both occur; the count is unchanged and overflow is not set.
REQ-028 Push and pop in the same cycle when empty: the pop is ignored because key_valid=0; the push occurs.
REQ-029 Read and write pointers SHALL be FIFO_AW bits wide and wrap modulo depth; fifo_count tracks 0..2**FIFO_AW exactly.
REQ-030 Watchdog: while bit counter != 0, count clk cycles since the last strobe; at TIMEOUT_CYC, reset the bit counter and pend flags and set timeout_err. The watchdog is idle while the counter == 0.
REQ-031 If clr_err and a new error event occur in the same cycle, the flag SHALL end set (set wins).

Reset
REQ-032 When clrn==0 at a clk edge: FIFO empty, pointers 0, fifo_count=0, key_valid=0, key_code=0, key_ext=0, key_brk=0, all sticky flags 0, bit counter 0, pend flags 0, watchdog 0, synchronisers 3'b111.
REQ-033 Reset mid-frame SHALL discard the partial frame; the first strobe after release is treated as a start bit.

Verification
REQ-034 Send frame 0x1C (valid parity) -> exactly one event: code=1C, ext=0, brk=0; key_valid rises 2 clk after the stop-bit strobe.
REQ-035 Send E0,F0,75 -> one event: code=75, ext=1, brk=1; fifo_count=1.
REQ-036 Send 0x1C with a flipped parity bit -> no event, parity_err=1; then F0 followed by a bad frame, then 1C -> event with brk=0.
REQ-037 Hold key_ready=0 and send 9 codes with FIFO_AW=3 -> fifo_count=8, overflow=1, head equals the first code; then drain -> codes 1-8 in order.
REQ-038 Send 4 bits then stop toggling ps2_clk for TIMEOUT_CYC cycles -> timeout_err=1, bit counter=0; a following full frame 0x69 decodes correctly.
REQ-039 Assert clrn=0 for one cycle mid-frame with 3 events queued -> all outputs at reset values; a subsequent frame 0x70 decodes correctly; a clr_err pulse clears the flags.
